// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
// The master drives the request, the slave returns the results.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Controller and datapath share one FSM; results hold until the next start.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_count;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Partial remainder always stays below the divisor, so its extra
    // top bit is zero and only the trial needs the borrow position.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_dbz   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quo   <= '1;
                            r_rem   <= bus.dividend;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_quo   <= bus.dividend;
                            r_rem   <= '0;
                            r_dvs   <= bus.divisor;
                            r_count <= CW'(WIDTH);
                            r_dbz   <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state == S_CALC);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider against hand-computed results.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_seq_divider;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start; returns in the cycle after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'hA5;
        bus.divisor  = 8'h5A;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) nbusy++;
            tick();
            lat++;
        end
        check("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic div_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] eq,
                          input logic [7:0] er, input logic ez);
        int lat;
        int nb;
        start_op(a, b);
        wait_done(lat, nb);
        check({tag, "_lat"}, lat, ez ? 0 : 8);
        check({tag, "_busy"}, nb, ez ? 0 : 8);
        check({tag, "_q"}, {24'd0, bus.quotient}, {24'd0, eq});
        check({tag, "_r"}, {24'd0, bus.remainder}, {24'd0, er});
        check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
        tick();
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        int nb;
        int extra;
        logic [7:0] ca;
        logic [7:0] cb;
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", {24'd0, bus.quotient}, 32'd0);
        check("rst_r", {24'd0, bus.remainder}, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

        div_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        div_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        div_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        div_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        div_op("d77_0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
        div_op("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

        // A start pulse mid-calculation must be ignored entirely.
        start_op(8'd100, 8'd9);
        tick();
        tick();
        tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        tick();
        bus.start    = 1'b0;
        wait_done(lat, nb);
        check("mid_lat", lat, 4);
        check("mid_q", {24'd0, bus.quotient}, 32'd11);
        check("mid_r", {24'd0, bus.remainder}, 32'd1);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        check("mid_no_second_done", extra, 0);

        // Reset four cycles into a calculation.
        start_op(8'd50, 8'd3);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        check("mrst_q", {24'd0, bus.quotient}, 32'd0);
        check("mrst_r", {24'd0, bus.remainder}, 32'd0);
        check("mrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        div_op("d60_7", 8'd60, 8'd7, 8'd8, 8'd4, 1'b0);

        // Back-to-back sweep with start held high.
        ca           = 8'($urandom_range(0, 255));
        cb           = 8'($urandom_range(1, 255));
        bus.dividend = ca;
        bus.divisor  = cb;
        bus.start    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                wait_done(lat, nb);
                check("sw_first_gap", lat, 9);
            end else begin
                tick();
                wait_done(lat, nb);
                check("sw_gap", lat + 1, 10);
            end
            check("sw_inv",
                  32'(bus.quotient) * 32'(cb) + 32'(bus.remainder),
                  32'(ca));
            check("sw_rlt", {31'd0, bus.remainder < cb}, 32'd1);
            ca           = 8'($urandom_range(0, 255));
            cb           = 8'($urandom_range(1, 255));
            bus.dividend = ca;
            bus.divisor  = cb;
        end
        bus.start = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned integer divider using restoring shift-subtract. It computes one quotient bit per clock and uses a start/done handshake. It is the inverse-operation companion to the team's sequential multiplier and sits beside it as an arithmetic coprocessor. Controller and datapath live in this one module. Operands are captured on start, and results stay stable after done until the next accepted start.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  unsigned numerator, captured when start is accepted
- divisor  in  WIDTH  unsigned denominator, captured when start is accepted
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse, high while in DONE
- quotient  out  WIDTH  result; valid from done, held until next accepted start
- remainder  out  WIDTH  result; valid from done, held until next accepted start
- div_by_zero  out  1  set with done when divisor==0; held until next accepted start

## Operation
- States: IDLE, CALC, DONE. State is registered; busy = (state==CALC) and done = (state==DONE), decoded from registered state so both are glitch-free.
- IDLE, start=1, divisor≠0: load the quotient register with dividend, the remainder register (WIDTH+1 bits) with 0, and the divisor register; set count=WIDTH; clear div_by_zero; go to CALC.
- IDLE, start=1, divisor==0: quotient = all ones, remainder = dividend, div_by_zero = 1; go straight to DONE. No iterations run.
- IDLE, start=0: stay in IDLE; all registers hold.
- CALC, each cycle:
  - trial = {rem[WIDTH-1:0], quo[WIDTH-1]} − {1'b0, dvs}, computed at WIDTH+1 bits.
  - trial MSB = 0: rem ← trial; quo ← {quo[WIDTH-2:0], 1}.
  - Otherwise: rem ← {rem[WIDTH-1:0], quo[WIDTH-1]}; quo ← {quo[WIDTH-2:0], 0}.
  - count decrements by 1. On the iteration where count==1, go to DONE.
- DONE: go to IDLE unconditionally after one cycle.
- Output mapping: quotient = quo, and remainder = rem[WIDTH-1:0].
- start is ignored in CALC and DONE. It is never queued. A start held high through DONE is accepted in the first IDLE cycle.
- dividend and divisor may change freely after the accepting edge. Only the captured copies are used.
- Invariant at done with divisor≠0: dividend == quotient*divisor + remainder, and remainder < divisor.

## Timing
- Reset (synchronous, highest priority, any state including mid-CALC): state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, count = 0. Any in-flight operation is discarded.
- Accept edge E0 is the edge at which IDLE samples start=1.
- Normal operation:
  - busy is high in the cycles after edges E0 through E(WIDTH−1).
  - Iterations complete at edges E1 through E(WIDTH).
  - done is high for exactly the one cycle after E(WIDTH).
  - Back in IDLE after E(WIDTH+1).
- Divide by zero: done is high in the cycle after E0, busy never rises, and the block is back in IDLE after E1.
- Minimum start-to-start spacing:
  - WIDTH+2 edges normally.
  - 2 edges for divide by zero.
- Results change only at iteration edges and at E0. They are stable from done onward.

## Test plan
- WIDTH=8, dividend=200, divisor=7, one-cycle start → busy for 8 cycles, then a single done pulse with quotient=28, remainder=4, div_by_zero=0.
- 5/9 → quotient=0, remainder=5. 255/1 → quotient=255, remainder=0. 255/255 → quotient=1, remainder=0. Each has done exactly 8 edges after accept.
- 77/0 → done in the cycle after accept, quotient=255, remainder=77, div_by_zero=1, busy never asserted. The next valid division (10/3 → 3, 1) clears div_by_zero.
- start pulsed mid-CALC, with new operands 9/2 → ignored. The first result (100/9 → 11, 1) is correct, and no second done follows.
- reset asserted 4 cycles into CALC → all outputs 0 on the next edge. A following 60/7 → 8, 4 with normal latency.
- Randomized sweep of 1000 operand pairs with start held high continuously → every done satisfies the division invariant, and accepts are spaced exactly WIDTH+2 edges apart.
